// File: rtl/m_uart_tx_pkg.sv
// rtl/m_uart_tx_pkg.sv - shared constants and FSM encoding for the UART word transmitter
package m_uart_tx_pkg;

  localparam int TX_COUNT_DEF   = 49;
  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = BITS_PER_BYTE * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/m_txfifo.sv
// rtl/m_txfifo.sv - synchronous word FIFO with combinational read head
module m_txfifo
  import m_uart_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_BITS,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             w_clk,
  input  logic             rstx,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Full/empty come from the registered count only, so a pop never frees a slot for the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge w_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge w_clk or negedge rstx) begin
    if (!rstx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_tx.sv
// rtl/m_uart_tx.sv - FIFO-buffered UART transmitter sending 32-bit words as four 8N1 frames
module m_uart_tx
  import m_uart_tx_pkg::*;
#(
  parameter int TX_COUNT   = TX_COUNT_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        w_clk,
  input  logic        dram_rstx_async,
  input  logic        w_we,
  input  logic [31:0] w_din,
  output logic        w_full,
  output logic        w_busy,
  output logic        w_ovf,
  output logic        w_txd
);

  localparam int TW  = (TX_COUNT > 0) ? $clog2(TX_COUNT + 1) : 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TX_COUNT);

  logic rst_meta;
  logic rstx;

  // Assertion reaches every flop at once; release is retimed through two flops.
  always_ff @(posedge w_clk or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      rst_meta <= 1'b0;
      rstx     <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rstx     <= rst_meta;
    end
  end

  logic             fifo_full;
  logic             fifo_empty;
  logic [FAW:0]     fifo_count;
  logic [31:0]      fifo_rdata;
  logic             pop;

  m_txfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_BITS)
  ) u_fifo (
    .w_clk   (w_clk),
    .rstx    (rstx),
    .wr_en   (w_we),
    .wr_data (w_din),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign w_full = fifo_full;

  always_ff @(posedge w_clk or negedge rstx) begin
    if (!rstx)                 w_ovf <= 1'b0;
    else if (w_we && fifo_full) w_ovf <= 1'b1;
  end

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [TW-1:0] bit_tmr;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic        tick;
  logic        last_bit;
  logic        last_byte;
  logic        txd_d;
  logic        busy_d;

  assign tick      = (bit_tmr == TIMER_LAST);
  assign last_bit  = (bit_idx == 3'(BITS_PER_BYTE - 1));
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge w_clk or negedge rstx) begin
    if (!rstx) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
      ST_START: if (tick) state_nxt = ST_DATA;
      ST_DATA:  if (tick && last_bit) state_nxt = ST_STOP;
      ST_STOP:  if (tick) state_nxt = (!last_byte || !fifo_empty) ? ST_START : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    pop   = 1'b0;
    case (state)
      ST_IDLE:  pop   = !fifo_empty;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shreg[0];
      ST_STOP:  pop   = tick && last_byte && !fifo_empty;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_nxt != ST_IDLE) || (fifo_count != '0);
  end

  // The line is driven from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge w_clk or negedge rstx) begin
    if (!rstx) begin
      bit_tmr  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      w_txd    <= 1'b1;
      w_busy   <= 1'b0;
    end else begin
      w_txd   <= txd_d;
      w_busy  <= busy_d;
      bit_tmr <= (state == ST_IDLE || tick) ? '0 : bit_tmr + TW'(1);
      if (pop) begin
        shreg    <= fifo_rdata;
        bit_idx  <= '0;
        byte_idx <= '0;
      end else begin
        if (state == ST_DATA && tick) begin
          shreg   <= {1'b0, shreg[31:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        if (state == ST_STOP && tick && !last_byte) byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: doc/m_uart_tx.md
M_UART_TX -- requirements
Module: m_uart_tx

Interface
REQ-001 SHALL have parameter TX_COUNT, default 49, bit period = TX_COUNT+1 w_clk cycles (matches receiver RX_COUNT).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, word entries (power of two, >=2).
REQ-003 w_clk  input  1  clock, all state on rising edge.
REQ-004 dram_rstx_async  input  1  reset, asynchronous, active-low.
REQ-005 w_we  input  1  write strobe for one 32-bit word.
REQ-006 w_din  input  32  word to transmit.
REQ-007 w_full  output  1  FIFO holds FIFO_DEPTH words; writes ignored.
REQ-008 w_busy  output  1  FIFO non-empty or frame in progress.
REQ-009 w_ovf  output  1  sticky: a write was dropped.
REQ-010 w_txd  output  1  UART serial line, idle high.

Function
REQ-011 Write accepted iff w_we=1 and w_full=0 at the clock edge; w_full derives from current count only, so a write while full is dropped even if a pop occurs that cycle.
REQ-012 Dropped write SHALL set w_ovf=1; w_ovf clears only on reset.
REQ-013 Simultaneous accepted write and pop SHALL leave count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-014 FSM states IDLE, START, DATA, STOP; each bit state holds TX_COUNT+1 cycles via a bit-timer counting 0..TX_COUNT.
REQ-015 IDLE: if FIFO non-empty, pop word into shift register, byte index=0, go START; else stay, w_txd=1.
REQ-016 START drives 0; DATA drives 8 bits LSB first (bit counter 0..7); STOP drives 1.
REQ-017 Word sent as 4 bytes, byte 0 = w_din[7:0] first, byte 3 = w_din[31:24] last (inverse of the loader's LSB-first assembly).
REQ-018 STOP end: byte index<3 -> START of next byte; byte index=3 and FIFO non-empty -> pop and START directly; else IDLE; no idle bit between back-to-back frames.
REQ-019 w_txd SHALL be registered (glitch-free); first falling edge occurs on the second rising edge after the edge accepting a write into an empty idle block.
REQ-020 One word = 40 bit periods = 40*(TX_COUNT+1) cycles.
REQ-021 w_busy SHALL drop the cycle the FSM re-enters IDLE with FIFO empty.

Reset
REQ-022 Reset SHALL asynchronously force w_txd=1, w_full=0, w_busy=0, w_ovf=0, FSM=IDLE, counters and FIFO pointers=0, even mid-frame; FIFO contents discarded.
REQ-023 Deassertion SHALL be synchronised in-block to w_clk (two-flop) before releasing the FSM.

Structure
REQ-024 Shared package SHALL hold FSM state encoding, default TX_COUNT, bits-per-byte (8) and bytes-per-word (4) constants.
REQ-025 FIFO SHALL be a separate sub-module m_txfifo (synchronous, combinational read head, full/empty/count outputs); serializer FSM stays in m_uart_tx.

Verification
REQ-026 TX_COUNT=49, write 0x44332211 -> bytes 0x11,0x22,0x33,0x44; byte 0x11 line = 0,1,0,0,0,1,0,0,0,1 each 50 cycles; w_busy high 2000 cycles.
REQ-027 Loopback w_txd into receiver with RX_COUNT=49, words 0xDEADBEEF,0x00000000,0xFFFFFFFF -> received bytes EF,BE,AD,DE,00x4,FFx4, no framing slips.
REQ-028 FIFO_DEPTH=16, 18 writes on consecutive cycles -> writes 1..17 accepted (word 1 popped), w_full high after write 17, write 18 dropped, w_ovf=1; all 17 words transmitted in order.
REQ-029 Two back-to-back words, TX_COUNT=3 -> 8 contiguous frames, 320 cycles, no high gap beyond stop bits.
REQ-030 Reset asserted during DATA bit 4 of byte 2 with 3 words queued -> w_txd=1 same cycle, w_busy=0, w_ovf=0; after release no further transmission.
REQ-031 Write into empty block at edge N -> w_txd low from edge N+2, w_busy high from edge N+1.
